// File: rtl/ncc_load_sequencer.sv
// ncc_load_sequencer
//   Frame-level controller for the NCC datapath. Accepts the host byte stream
//   (valid/ready) and steers it first into the descriptor shift register and
//   then, row-major, into the per-row window BRAMs. Once the window is full it
//   fires the correlator, waits for its completion pulse and reports the frame.
//
//   Build option: define NCC_SEQ_TIMEOUT_EN to add a compute watchdog that
//   abandons the frame after TIMEOUT_CYCLES cycles in COMPUTE without
//   corr_done. Without it, timeout is tied low and COMPUTE waits forever.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     start                    one-cycle frame request (IDLE only)
//     abort                    synchronous abort, highest priority
//     in_valid/in_data/in_ready host byte handshake
//     desc_load/desc_shift/desc_byte  descriptor register strobes and byte
//     win_wr/win_row/win_addr/win_data window row BRAM write port
//     corr_start/corr_done     correlator handshake
//     busy, frame_done, timeout frame status

module ncc_load_sequencer #(
    parameter int DESC_PIXELS    = 256,
    parameter int WIN_ROWS       = 16,
    parameter int WIN_COLS       = 40,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        desc_load,
    output logic                        desc_shift,
    output logic [7:0]                  desc_byte,
    output logic                        win_wr,
    output logic [$clog2(WIN_ROWS)-1:0] win_row,
    output logic [$clog2(WIN_COLS)-1:0] win_addr,
    output logic [7:0]                  win_data,
    output logic                        corr_start,
    input  logic                        corr_done,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        timeout
);

    localparam int DCW = (DESC_PIXELS > 1) ? $clog2(DESC_PIXELS) : 1;
    localparam int RW  = $clog2(WIN_ROWS);
    localparam int CW  = $clog2(WIN_COLS);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_DESC = 3'd1;
    localparam logic [2:0] S_LOAD_WIN  = 3'd2;
    localparam logic [2:0] S_COMPUTE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]     state, state_n;
    logic [DCW-1:0] desc_cnt, desc_cnt_n;
    logic [RW-1:0]  row, row_n;
    logic [CW-1:0]  col, col_n;
    logic           corr_start_n;
    logic           accept;
    logic           desc_last, col_last, row_last;

    // Abort also drops in_ready so nothing is written in the abort cycle.
    assign in_ready = ((state == S_LOAD_DESC) || (state == S_LOAD_WIN)) && !abort;
    assign accept   = in_valid && in_ready;

    assign desc_last = (desc_cnt == DCW'(DESC_PIXELS - 1));
    assign col_last  = (col == CW'(WIN_COLS - 1));
    assign row_last  = (row == RW'(WIN_ROWS - 1));

    assign desc_load  = accept && (state == S_LOAD_DESC) && (desc_cnt == '0);
    assign desc_shift = accept && (state == S_LOAD_DESC) && (desc_cnt != '0);
    assign desc_byte  = in_data;

    assign win_wr   = accept && (state == S_LOAD_WIN);
    assign win_row  = row;
    assign win_addr = col;
    assign win_data = in_data;

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE) && !abort;

`ifdef NCC_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt, wd_cnt_n;
    logic           wd_expire;

    // Expiry is the TIMEOUT_CYCLES-th COMPUTE cycle; a corr_done in that
    // same cycle still completes the frame normally.
    assign wd_expire = (state == S_COMPUTE) && !corr_done &&
                       (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign timeout   = wd_expire && !abort;
`else
    // Watchdog not built; the comparison is constant false and keeps the
    // parameter referenced so instantiations are identical in both builds.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n      = state;
        desc_cnt_n   = desc_cnt;
        row_n        = row;
        col_n        = col;
        corr_start_n = 1'b0;
`ifdef NCC_SEQ_TIMEOUT_EN
        wd_cnt_n     = wd_cnt;
`endif
        if (abort) begin
            state_n    = S_IDLE;
            desc_cnt_n = '0;
            row_n      = '0;
            col_n      = '0;
`ifdef NCC_SEQ_TIMEOUT_EN
            wd_cnt_n   = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n    = S_LOAD_DESC;
                        desc_cnt_n = '0;
                    end
                end
                S_LOAD_DESC: begin
                    if (accept) begin
                        if (desc_last) begin
                            state_n    = S_LOAD_WIN;
                            desc_cnt_n = '0;
                            row_n      = '0;
                            col_n      = '0;
                        end else begin
                            desc_cnt_n = desc_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_WIN: begin
                    if (accept) begin
                        if (col_last) begin
                            col_n = '0;
                            if (row_last) begin
                                state_n      = S_COMPUTE;
                                row_n        = '0;
                                corr_start_n = 1'b1;
`ifdef NCC_SEQ_TIMEOUT_EN
                                wd_cnt_n     = '0;
`endif
                            end else begin
                                row_n = row + 1'b1;
                            end
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (corr_done) begin
                        state_n = S_DONE;
`ifdef NCC_SEQ_TIMEOUT_EN
                    end else if (wd_expire) begin
                        state_n  = S_IDLE;
                        wd_cnt_n = '0;
                    end else begin
                        wd_cnt_n = wd_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // corr_start is registered off the LOAD_WIN -> COMPUTE transition so it
    // lines up with the first COMPUTE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            desc_cnt   <= '0;
            row        <= '0;
            col        <= '0;
            corr_start <= 1'b0;
        end else begin
            state      <= state_n;
            desc_cnt   <= desc_cnt_n;
            row        <= row_n;
            col        <= col_n;
            corr_start <= corr_start_n;
        end
    end

`ifdef NCC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_ncc_load_sequencer.sv
// tb_ncc_load_sequencer
//   Randomized scoreboard bench for ncc_load_sequencer. The driver computes
//   every expected strobe (kind, byte, row, column, cycle) from the frame
//   layout and queues it; an independent monitor pops one entry per strobe
//   the DUT presents and compares.

module tb_ncc_load_sequencer;

    localparam int DP   = 256;
    localparam int WR   = 16;
    localparam int WC   = 40;
    localparam int TO   = 16;
    localparam int NWIN = WR * WC;

    localparam int K_LOAD  = 0;
    localparam int K_SHIFT = 1;
    localparam int K_WR    = 2;
    localparam int K_CS    = 3;
    localparam int K_FD    = 4;
    localparam int K_TO    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, in_valid, corr_done;
    logic [7:0] in_data;
    logic       in_ready, desc_load, desc_shift, win_wr;
    logic [7:0] desc_byte, win_data;
    logic [3:0] win_row;
    logic [5:0] win_addr;
    logic       corr_start, busy, frame_done, timeout;

    typedef struct {
        int kind;
        int data;
        int row;
        int addr;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;

    ncc_load_sequencer #(
        .DESC_PIXELS   (DP),
        .WIN_ROWS      (WR),
        .WIN_COLS      (WC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .desc_load (desc_load),
        .desc_shift(desc_shift),
        .desc_byte (desc_byte),
        .win_wr    (win_wr),
        .win_row   (win_row),
        .win_addr  (win_addr),
        .win_data  (win_data),
        .corr_start(corr_start),
        .corr_done (corr_done),
        .busy      (busy),
        .frame_done(frame_done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int k, input int d, input int r, input int a, input int c);
        ev_t e;
        e.kind = k; e.data = d; e.row = r; e.addr = a; e.cyc = c;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic pop_cmp(input ev_t got);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: kind=%0d data=%0d row=%0d addr=%0d cyc=%0d, expected none",
                     got.kind, got.data, got.row, got.addr, got.cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != got.kind || e.data != got.data || e.row != got.row ||
                e.addr != got.addr || e.cyc != got.cyc) begin
                n_err++;
                $display("FAIL strobe: got kind=%0d data=%0d row=%0d addr=%0d cyc=%0d, expected kind=%0d data=%0d row=%0d addr=%0d cyc=%0d",
                         got.kind, got.data, got.row, got.addr, got.cyc,
                         e.kind, e.data, e.row, e.addr, e.cyc);
            end
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (desc_load)  pop_cmp(mk(K_LOAD,  int'(desc_byte), 0, 0, cyc));
            if (desc_shift) pop_cmp(mk(K_SHIFT, int'(desc_byte), 0, 0, cyc));
            if (win_wr)     pop_cmp(mk(K_WR, int'(win_data), int'(win_row), int'(win_addr), cyc));
            if (corr_start) pop_cmp(mk(K_CS, 0, 0, 0, cyc));
            if (frame_done) pop_cmp(mk(K_FD, 0, 0, 0, cyc));
            if (timeout)    pop_cmp(mk(K_TO, 0, 0, 0, cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_at_negedge(input string name, input int act_sel, input int exp_v);
        @(negedge clk);
        case (act_sel)
            0: chk(name, int'(busy), exp_v);
            1: chk(name, int'(in_ready), exp_v);
            default: chk(name, int'(timeout), exp_v);
        endcase
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 valid held high, 1 toggling, 2 random gaps.
    // cd_delay: cycles after corr_start before corr_done (-1 = never).
    // abort_idx: frame byte index at which abort is raised (-1 = none).
    task automatic run_frame(input int vmode, input int cd_delay, input int abort_idx, input bit inject);
        int k;
        int d;
        int b;
        bit v;
        bit tg;
        k  = 0;
        tg = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (k < DP + NWIN) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin tg = ~tg; v = tg; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            d = int'($urandom_range(0, 255));
            in_valid = v;
            in_data  = 8'(d);
            if (inject && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) start = 1'b1;
                else corr_done = 1'b1;
            end
            if (v && k == abort_idx) begin
                abort = 1'b1;
                @(negedge clk);
                chk("abort_in_ready", int'(in_ready), 0);
                @(posedge clk);
                #1;
                abort = 1'b0; in_valid = 1'b0; start = 1'b0; corr_done = 1'b0;
                check_at_negedge("abort_busy", 0, 0);
                return;
            end
            if (v) begin
                if (k < DP) begin
                    exp_q.push_back(mk((k == 0) ? K_LOAD : K_SHIFT, d, 0, 0, cyc));
                end else begin
                    b = k - DP;
                    exp_q.push_back(mk(K_WR, d, b / WC, b % WC, cyc));
                end
                k++;
            end
            step();
            start = 1'b0;
            corr_done = 1'b0;
        end
        in_valid = 1'b0;
        // Now in the cycle after the last window byte.
        exp_q.push_back(mk(K_CS, 0, 0, 0, cyc));
        if (cd_delay >= 0) begin
            repeat (cd_delay) step();
            corr_done = 1'b1;
            exp_q.push_back(mk(K_FD, 0, 0, 0, cyc + 1));
            step();
            corr_done = 1'b0;
            step();
            check_at_negedge("busy_after_done", 0, 0);
        end else begin
`ifdef NCC_SEQ_TIMEOUT_EN
            exp_q.push_back(mk(K_TO, 0, 0, 0, cyc + TO - 1));
            repeat (TO) step();
            check_at_negedge("busy_after_timeout", 0, 0);
`else
            repeat (40) step();
            @(negedge clk);
            chk("busy_in_compute", int'(busy), 1);
            chk("timeout_low", int'(timeout), 0);
            @(posedge clk);
            #1;
            // Abort with a coincident corr_done: abort wins, no frame_done.
            abort = 1'b1;
            corr_done = 1'b1;
            step();
            abort = 1'b0;
            corr_done = 1'b0;
            check_at_negedge("busy_after_compute_abort", 0, 0);
`endif
        end
    endtask

    initial begin
        #1000000;
        n_checks++;
        n_err++;
        $display("FAIL global_time_limit: simulation did not complete, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        corr_done = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   int'(in_ready),   0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_desc_load",  int'(desc_load),  0);
        chk("rst_win_wr",     int'(win_wr),     0);
        chk("rst_corr_start", int'(corr_start), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_timeout",    int'(timeout),    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        corr_done = 1'b0;
        step();

        run_frame(0, 10, -1, 1'b0);
        run_frame(1, 10, -1, 1'b0);
        run_frame(0, 0, DP + 300, 1'b0);
        run_frame(2, 0, -1, 1'b1);
        run_frame(2, 0, 50, 1'b1);

        // corr_done while idle must not start anything.
        corr_done = 1'b1;
        step();
        corr_done = 1'b0;
        check_at_negedge("idle_corr_done_busy", 0, 0);

        // Asynchronous reset in the middle of the descriptor phase.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            exp_q.push_back(mk((i == 0) ? K_LOAD : K_SHIFT, i & 255, 0, 0, cyc));
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        run_frame(2, int'($urandom_range(1, 20)), -1, 1'b1);
        run_frame(2, -1, -1, 1'b0);
        run_frame(0, 3, -1, 1'b0);

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ncc_load_sequencer.md
Name: ncc_load_sequencer

Overview:
- Frame-level controller for the NCC datapath.
- Accepts the host byte stream with a valid/ready handshake and steers it into the descriptor shift register, then into the per-row window BRAMs.
- Then fires the correlator, waits for its completion, and reports frame completion.
- Sits between the PCI byte interface and the descriptor register, window row BRAMs and correlation core.

Parameters:
- DESC_PIXELS, 256, descriptor bytes per frame (one byte per pixel).
- WIN_ROWS, 16, window rows; one BRAM per row.
- WIN_COLS, 40, pixels per window row. Total window bytes = WIN_ROWS*WIN_COLS = 640.
- TIMEOUT_CYCLES, 4096, compute watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE
- abort  input  1  synchronous abort; returns to IDLE from any state
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  sequencer accepts a byte this cycle
- desc_load  output  1  load in_data into descriptor register low byte
- desc_shift  output  1  shift descriptor register left 8 and insert byte
- desc_byte  output  8  byte to descriptor register (= in_data)
- win_wr  output  1  write strobe to the selected window row BRAM
- win_row  output  $clog2(WIN_ROWS)  selected row BRAM
- win_addr  output  $clog2(WIN_COLS)  address within row BRAM
- win_data  output  8  window pixel (= in_data)
- corr_start  output  1  one-cycle start pulse to correlator
- corr_done  input  1  correlator completion pulse
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse on successful completion
- timeout  output  1  one-cycle pulse on watchdog expiry (0 without feature)

Behaviour:
- States: IDLE, LOAD_DESC, LOAD_WIN, COMPUTE, DONE. State and counters are in a registered state machine; the next state is computed combinationally.
- Accept = in_valid && in_ready.
- in_ready = 1 only in LOAD_DESC and LOAD_WIN.
- Reset (async): state IDLE, all counters 0, corr_start/frame_done/timeout/busy = 0. Combinational strobes are 0 because in_ready = 0.
- IDLE: start -> LOAD_DESC. The desc counter is cleared on entry.
- LOAD_DESC, per accepted byte (same cycle as accept, combinational):
  - First byte (desc_cnt == 0): desc_load = 1.
  - Later bytes: desc_shift = 1.
  - desc_byte = in_data; desc_cnt increments.
  - On the accept with desc_cnt == DESC_PIXELS-1: go to LOAD_WIN; col and row are cleared.
  - No accept: counters hold and strobes stay 0.
- LOAD_WIN, per accepted byte:
  - win_wr = 1, win_row = row, win_addr = col, win_data = in_data.
  - Ordering is row-major: col increments; at col == WIN_COLS-1, col wraps to 0 and row increments.
  - On the accept at row == WIN_ROWS-1 and col == WIN_COLS-1: go to COMPUTE.
- COMPUTE:
  - corr_start is registered high for exactly the first cycle in COMPUTE.
  - Waits for corr_done, then goes to DONE.
  - A corr_done coincident with the corr_start cycle is honoured.
- DONE: frame_done = 1 for one cycle, then IDLE.
  - Earliest next start is accepted the cycle after returning to IDLE.
- Latency from the last window byte accepted:
  - corr_start high in cycle +1.
  - frame_done high in the cycle after the cycle corr_done is sampled.
- abort has priority over every other event, including simultaneous start or corr_done:
  - Next state IDLE, counters cleared, no frame_done.
  - Strobes in the abort cycle are suppressed: in_ready = 0 in the abort cycle.
- start outside IDLE is ignored. corr_done outside COMPUTE is ignored.
- Async reset mid-frame discards all progress; the BRAM contents are left as written.

Optional Feature:
- Macro NCC_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to COMPUTE and increments each COMPUTE cycle.
  - If it reaches TIMEOUT_CYCLES without corr_done, the block pulses timeout for one cycle and goes to IDLE; frame_done is not asserted.
  - corr_done in the expiry cycle wins: normal DONE, no timeout.
- Undefined: no watchdog logic; timeout tied 0; COMPUTE waits indefinitely.

Test Plan:
- Reset then start, 256 desc bytes + 640 window bytes with in_valid held high:
  - desc_load once, on byte 0; desc_shift 255 times.
  - win_wr 640 times; last write is row=15, addr=39.
  - corr_start the following cycle.
  - corr_done 10 cycles later -> frame_done one cycle after it; busy low afterward.
- Same stream with in_valid toggling 1/0 every cycle: identical strobe counts, row/col wrap at each addr 39 -> 0, no strobes on idle cycles.
- abort asserted at window byte 300 (row 7, col 20): in_ready 0 that cycle, IDLE next, no corr_start. A new frame then starts at desc_cnt 0 (desc_load on its first byte).
- start pulsed during LOAD_WIN, and corr_done pulsed during LOAD_DESC: both ignored; counts and state unaffected.
- With NCC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, corr_done never sent: timeout pulse after 16 COMPUTE cycles, no frame_done, IDLE.
- Without NCC_SEQ_TIMEOUT_EN, same stimulus: timeout stays 0 and the block remains in COMPUTE.
